sd_spi_byte_engine: RTL and testbench
=====================================

// Module: sd_spi_byte_engine
// PURPOSE
//   SPI master byte engine for the SD-card interface: clock divider plus 8-bit full-duplex shifter.
//   Generates SPI_CLK at a slow init rate (~400 kHz) or a fast work rate (25 MHz), both derived from DataClock.
//   Shifts out one command/data byte while capturing one response byte.
//   Pulses ByteDone once per byte so the SD command FSM above it can supply the next byte.
// PARAMETERS
//   CLK_FREQ_HZ   50_000_000  frequency of DataClock
//   INIT_FREQ_HZ  400_000     SPI_CLK rate when FastMode=0
//   WORK_FREQ_HZ  25_000_000  SPI_CLK rate when FastMode=1
//   DIV_WIDTH     8           width of the half-period counter (must hold CLK_FREQ_HZ/(2*INIT_FREQ_HZ))
// PORTS
//   DataClock   in   1  system clock; all logic on its rising edge
//   Reset       in   1  synchronous, active-high
//   SPI_Enable  in   1  1 = run transfers continuously; 0 = idle
//   FastMode    in   1  0 = INIT rate, 1 = WORK rate
//   OutputData  in   8  next byte to transmit; sampled at each byte start
//   InputData   out  8  last fully received byte
//   ByteDone    out  1  one-cycle pulse when InputData is updated
//   SPI_CLK     out  1  serial clock (CPOL=0)
//   SPI_MOSI    out  1  serial data out, MSB first
//   SPI_MISO    in   1  serial data in, sampled on SPI_CLK rising edge
// BEHAVIOUR
//   Interface: clock DataClock; reset Reset, synchronous, active-high.
//   Reset values: SPI_CLK=0, SPI_MOSI=1, InputData=8'hFF, ByteDone=0; divider and bit counter cleared.
//   Divider:
//   - Half-period count N = CLK_FREQ_HZ/(2*f), integer floor, minimum 1.
//   - Defaults: init N=62 (~403 kHz); work N=1 (25 MHz, SPI_CLK toggles every cycle).
//   - A tick occurs when the counter reaches N-1; the counter then returns to 0.
//   Mode 0, MSB first:
//   - Byte start (enable rising, or right after previous byte): load tx shift from OutputData, SPI_MOSI=bit7.
//   - Odd tick: SPI_CLK 0->1, shift SPI_MISO into rx LSB.
//   - Even tick: SPI_CLK 1->0, MOSI presents next bit.
//   - After the 8th falling edge: InputData<=rx byte; ByteDone=1 for exactly one DataClock cycle.
//   - The next byte is loaded in that same cycle: no SPI_CLK gap between back-to-back bytes.
//   Timing:
//   - Byte length = 16*N DataClock cycles: 16 in work mode, 992 in init mode.
//   - First rising SPI_CLK occurs N cycles after the cycle in which SPI_Enable is first seen high.
//   FastMode is sampled only at byte start; a change mid-byte takes effect on the next byte.
//   SPI_Enable=0 (or deasserted mid-byte):
//   - Next cycle: SPI_CLK=0, SPI_MOSI=1, counters cleared.
//   - Partial byte discarded; no ByteDone; InputData holds its last value.
//   Reset mid-byte: same as the reset values, overriding SPI_Enable.
//   Chip select is not driven here; it belongs to the command FSM.
// TESTING
//   1 Reset asserted 2 cycles -> SPI_CLK=0, SPI_MOSI=1, InputData=8'hFF, ByteDone=0.
//   2 FastMode=1, MOSI looped to MISO, OutputData=8'hA5, enable -> ByteDone at cycle 16 (one cycle wide), InputData=8'hA5.
//   3 FastMode=0, MISO=1 -> SPI_CLK period 124 cycles, ByteDone every 992 cycles, InputData=8'hFF.
//   4 Back-to-back 8'h40 then 8'h00, fast -> 16 continuous SPI_CLK pulses; MOSI sequence 0100_0000_0000_0000.
//   5 Drop SPI_Enable after 3 bits -> SPI_CLK=0, MOSI=1 next cycle; no ByteDone; InputData unchanged.
//   6 Toggle FastMode mid-byte -> current byte finishes at old rate, next byte at new rate.

Source files
------------

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 master byte engine for the SD-card link: SPI_CLK divider plus 8-bit
// full-duplex shifter that streams bytes back to back while SPI_Enable is held.
module sd_spi_byte_engine #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int INIT_FREQ_HZ = 400_000,
    parameter int WORK_FREQ_HZ = 25_000_000,
    parameter int DIV_WIDTH    = 8
) (
    input  logic       DataClock,
    input  logic       Reset,
    input  logic       SPI_Enable,
    input  logic       FastMode,
    input  logic [7:0] OutputData,
    output logic [7:0] InputData,
    output logic       ByteDone,
    output logic       SPI_CLK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    localparam int INIT_N_RAW = CLK_FREQ_HZ / (2 * INIT_FREQ_HZ);
    localparam int WORK_N_RAW = CLK_FREQ_HZ / (2 * WORK_FREQ_HZ);
    localparam int INIT_N     = (INIT_N_RAW < 1) ? 1 : INIT_N_RAW;
    localparam int WORK_N     = (WORK_N_RAW < 1) ? 1 : WORK_N_RAW;
    localparam logic [DIV_WIDTH-1:0] INIT_LAST = DIV_WIDTH'(INIT_N - 1);
    localparam logic [DIV_WIDTH-1:0] WORK_LAST = DIV_WIDTH'(WORK_N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] divCnt;
    logic [DIV_WIDTH-1:0] divLast;   // rate latched at byte start
    logic [3:0]           halfCnt;   // SPI_CLK edges within the byte
    logic [7:0]           txShift;
    logic [7:0]           rxShift;

    always_ff @(posedge DataClock) begin
        ByteDone <= 1'b0;
        if (Reset) begin
            state     <= IDLE;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= 1'b1;
            InputData <= 8'hFF;
            divCnt    <= '0;
            divLast   <= WORK_LAST;
            halfCnt   <= '0;
            txShift   <= '0;
            rxShift   <= '0;
        end else if (!SPI_Enable) begin
            state    <= IDLE;
            SPI_CLK  <= 1'b0;
            SPI_MOSI <= 1'b1;
            divCnt   <= '0;
            halfCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= RUN;
                    divCnt   <= '0;
                    halfCnt  <= '0;
                    txShift  <= OutputData;
                    SPI_MOSI <= OutputData[7];
                    divLast  <= FastMode ? WORK_LAST : INIT_LAST;
                end
                RUN: begin
                    if (divCnt == divLast) begin
                        divCnt  <= '0;
                        halfCnt <= halfCnt + 4'd1;
                        if (!halfCnt[0]) begin
                            SPI_CLK <= 1'b1;
                            rxShift <= {rxShift[6:0], SPI_MISO};
                        end else begin
                            SPI_CLK <= 1'b0;
                            if (halfCnt == 4'd15) begin
                                // Byte complete: publish and reload in the same cycle
                                // so the next byte starts without an SPI_CLK gap.
                                InputData <= rxShift;
                                ByteDone  <= 1'b1;
                                halfCnt   <= '0;
                                txShift   <= OutputData;
                                SPI_MOSI  <= OutputData[7];
                                divLast   <= FastMode ? WORK_LAST : INIT_LAST;
                            end else begin
                                SPI_MOSI <= txShift[6];
                                txShift  <= {txShift[6:0], 1'b0};
                            end
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Self-checking bench for sd_spi_byte_engine: vector table for single bytes, a
// received-byte scoreboard, and hand-written sequences for timing corner cases.
module tb_sd_spi_byte_engine;

    logic       DataClock = 1'b0;
    logic       Reset = 1'b1;
    logic       SPI_Enable = 1'b0;
    logic       FastMode = 1'b0;
    logic [7:0] OutputData = 8'h00;
    logic [7:0] InputData;
    logic       ByteDone;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       loopBack = 1'b0;
    logic       misoVal = 1'b0;

    assign SPI_MISO = loopBack ? SPI_MOSI : misoVal;

    sd_spi_byte_engine dut (
        .DataClock (DataClock),
        .Reset     (Reset),
        .SPI_Enable(SPI_Enable),
        .FastMode  (FastMode),
        .OutputData(OutputData),
        .InputData (InputData),
        .ByteDone  (ByteDone),
        .SPI_CLK   (SPI_CLK),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO)
    );

    always #5 DataClock = ~DataClock;

    int tests = 0;
    int fails = 0;
    logic [7:0] sbQ[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: every ByteDone must match the oldest expected byte.
    always @(negedge DataClock) begin
        if (ByteDone === 1'b1) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: ByteDone with InputData 0x%0h, no byte expected", InputData);
            end else begin
                check("sb_rx", int'(InputData), int'(sbQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge DataClock);
        #1;
    endtask

    // Counts edges waited, including the one that raised ByteDone.
    task automatic waitDone(output int cyc);
        bit done;
        done = 0;
        cyc = 0;
        while (!done) begin
            tick();
            cyc++;
            if (ByteDone) done = 1;
            else if (cyc > 3000) begin
                tests++;
                fails++;
                $display("FAIL wait_done: no ByteDone within %0d cycles", cyc);
                done = 1;
            end
        end
    endtask

    typedef struct {
        logic       fast;
        logic       loop;
        logic       miso;
        logic [7:0] tx;
        logic [7:0] expRx;
        int         expLat;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] lastRx;

    initial begin
        int lat, lat2, rise1, rise2, done1, done2, pulses, dones;
        logic prevClk;
        logic [15:0] seq;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'hA5, 8'hA5, 16};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 16};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h81, 16};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 16};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 16};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 992};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h12, 8'h12, 16};

        // Reset held for two cycles
        Reset = 1'b1;
        tick(); tick();
        check("rst_clk", int'(SPI_CLK), 0);
        check("rst_mosi", int'(SPI_MOSI), 1);
        check("rst_rx", int'(InputData), 8'hFF);
        check("rst_done", int'(ByteDone), 0);
        Reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            FastMode   = vecs[i].fast;
            loopBack   = vecs[i].loop;
            misoVal    = vecs[i].miso;
            OutputData = vecs[i].tx;
            SPI_Enable = 1'b1;
            sbQ.push_back(vecs[i].expRx);
            waitDone(lat);
            check($sformatf("vec%0d_latency", i), lat - 1, vecs[i].expLat);
            tick();
            check($sformatf("vec%0d_done_width", i), int'(ByteDone), 0);
            SPI_Enable = 1'b0;
            tick();
            check($sformatf("vec%0d_idle_clk", i), int'(SPI_CLK), 0);
            check($sformatf("vec%0d_idle_mosi", i), int'(SPI_MOSI), 1);
            tick();
        end
        lastRx = vecs[6].expRx;

        // Slow rate with MISO stuck high: clock period and byte cadence
        FastMode = 1'b0; loopBack = 1'b0; misoVal = 1'b1; OutputData = 8'h00;
        SPI_Enable = 1'b1;
        sbQ.push_back(8'hFF); sbQ.push_back(8'hFF);
        rise1 = -1; rise2 = -1; done1 = -1; done2 = -1;
        prevClk = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (SPI_CLK && !prevClk) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (ByteDone) begin
                if (done1 < 0) done1 = c;
                else if (done2 < 0) done2 = c;
            end
            prevClk = SPI_CLK;
        end
        SPI_Enable = 1'b0;
        tick(); tick();
        check("slow_first_rise", rise1, 62);
        check("slow_clk_period", rise2 - rise1, 124);
        check("slow_first_done", done1, 992);
        check("slow_done_interval", done2 - done1, 992);
        lastRx = 8'hFF;

        // Back-to-back 0x40, 0x00: continuous clock and MOSI sequence
        FastMode = 1'b1; loopBack = 1'b1; OutputData = 8'h40;
        SPI_Enable = 1'b1;
        sbQ.push_back(8'h40); sbQ.push_back(8'h00);
        tick();
        OutputData = 8'h00;
        pulses = 0; seq = '0; prevClk = SPI_CLK;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (SPI_CLK && !prevClk) begin
                pulses++;
                seq = {seq[14:0], SPI_MOSI};
            end
            prevClk = SPI_CLK;
        end
        SPI_Enable = 1'b0;
        tick(); tick();
        check("b2b_pulses", pulses, 16);
        check("b2b_mosi_seq", int'(seq), 16'h4000);
        lastRx = 8'h00;

        // Enable dropped mid-byte: partial byte discarded
        FastMode = 1'b1; loopBack = 1'b1; OutputData = 8'h00;
        SPI_Enable = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("abort_pre_clk", int'(SPI_CLK), 1);
        check("abort_pre_mosi", int'(SPI_MOSI), 0);
        SPI_Enable = 1'b0;
        tick();
        check("abort_clk", int'(SPI_CLK), 0);
        check("abort_mosi", int'(SPI_MOSI), 1);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ByteDone) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_rx_hold", int'(InputData), int'(lastRx));

        // FastMode toggled mid-byte: applies from the next byte
        FastMode = 1'b0; loopBack = 1'b1; OutputData = 8'hC3;
        SPI_Enable = 1'b1;
        sbQ.push_back(8'hC3); sbQ.push_back(8'hC3);
        tick();
        FastMode = 1'b1;
        waitDone(lat);
        waitDone(lat2);
        SPI_Enable = 1'b0;
        tick(); tick();
        check("mode_old_rate", lat, 992);
        check("mode_new_rate", lat2, 16);

        // Reset mid-byte overrides enable
        FastMode = 1'b1; OutputData = 8'h00;
        SPI_Enable = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        Reset = 1'b1;
        tick();
        check("rst_mid_clk", int'(SPI_CLK), 0);
        check("rst_mid_mosi", int'(SPI_MOSI), 1);
        check("rst_mid_rx", int'(InputData), 8'hFF);
        SPI_Enable = 1'b0;
        Reset = 1'b0;
        tick(); tick();

        check("sb_drained", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
